// File: rtl/mem_ctrl_pkg.sv
// Shared types and lane helpers for the sub-word memory access controller.
// Op encodings, FSM states, store sizes and byte-lane selection.
package mem_ctrl_pkg;

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SB = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_e;

  // op[1:0] doubles as the access size for both loads and stores
  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } size_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic op_is_load(logic [2:0] o);
    return (o == OP_LW) || (o == OP_LH) || (o == OP_LB);
  endfunction

  function automatic logic op_is_store(logic [2:0] o);
    return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
  endfunction

  function automatic logic op_misaligned(logic [2:0] o, logic [1:0] a);
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (o == OP_LW):                bad = (a != 2'b00);
      (o == OP_LH), (o == OP_SH):  bad = a[0];
      default:                     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] a);
    logic [3:0] m;
    unique case (sz)
      SZ_B:    m = 4'b0001 << a;
      SZ_H:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] lane_half(logic [31:0] w, logic a1);
    return a1 ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [7:0] lane_byte(logic [31:0] w, logic [1:0] a);
    return w[8*a +: 8];
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational store merge: replaces the addressed byte/half lane
// of the old memory word with store data (full word for SW).
module store_lane_merge
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  output logic [31:0] merged
);

  logic [3:0]  be;
  logic [31:0] rep;

  always_comb begin
    be = lane_mask(size, addr_lo);
    unique case (size)
      SZ_B:    rep = {4{wdata[7:0]}};
      SZ_H:    rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sub-word load/store sequencer between the CPU datapath and word memory.
// Define ALIGN_CHECK_EN to reject misaligned LW/LH/SH without accessing memory.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ext_sel,
  output logic [15:0] ext_half,
  output logic [7:0]  ext_byte,
  output logic [31:0] word_out,
  output logic        wb_ext,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  req_t             req_q;
  logic [31:0]      old_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timed_out;
  logic             bad_align;
  logic             accept;
  logic             rd_fire;
  logic [31:0]      merged;

  `ifdef ALIGN_CHECK_EN
  assign bad_align = op_misaligned(op, addr[1:0]);
  `else
  assign bad_align = 1'b0;
  `endif

  assign accept    = (state_q == ST_IDLE) && start;
  assign rd_fire   = (state_q == ST_RD) && mem_ready;
  // a ready on the last allowed cycle still completes the access
  assign timed_out = (cnt_q == CNT_LAST) && !mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (1'b1)
            !(op_is_load(op) || op_is_store(op)): state_d = ST_ERR;
            bad_align:                            state_d = ST_ERR;
            (op == OP_SW):                        state_d = ST_WR;
            default:                              state_d = ST_RD;
          endcase
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          state_d = op_is_load(req_q.op) ? ST_DONE : ST_WR;
        end else if (timed_out) begin
          state_d = ST_ERR;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end else if (timed_out) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      old_q    <= '0;
      cnt_q    <= '0;
      word_out <= '0;
      ext_half <= '0;
      ext_byte <= '0;
      ext_sel  <= 1'b0;
      wb_ext   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (mem_req && !mem_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept) begin
        req_q <= '{op: op, addr: addr, wdata: wdata};
      end
      if (rd_fire) begin
        old_q <= mem_rdata;
      end
      if (rd_fire && op_is_load(req_q.op)) begin
        word_out <= mem_rdata;
        ext_half <= lane_half(mem_rdata, req_q.addr[1]);
        ext_byte <= lane_byte(mem_rdata, req_q.addr[1:0]);
        ext_sel  <= (req_q.op == OP_LB);
        wb_ext   <= (req_q.op != OP_LW);
      end
    end
  end

  store_lane_merge u_merge (
    .old_word (old_q),
    .wdata    (req_q.wdata),
    .addr_lo  (req_q.addr[1:0]),
    .size     (size_e'(req_q.op[1:0])),
    .merged   (merged)
  );

  assign mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = {req_q.addr[31:2], 2'b00};
  assign mem_wdata = mem_we ? merged : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level
// model of memory contents, latency, timeout and load results.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic        ext_sel;
  logic [15:0] ext_half;
  logic [7:0]  ext_byte;
  logic [31:0] word_out;
  logic        wb_ext;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ext_sel   (ext_sel),
    .ext_half  (ext_half),
    .ext_byte  (ext_byte),
    .word_out  (word_out),
    .wb_ext    (wb_ext),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  logic [31:0] mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  bit          have_ld = 0;
  logic [2:0]  ld_op = '0;
  logic [31:0] ld_word = '0;
  logic [15:0] ld_half = '0;
  logic [7:0]  ld_byte = '0;

  function automatic int pick_dly();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return r % 4;
    if (r < 16) return TO - 1;
    if (r < 18) return TO;
    return 99;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input int dr, input int dw,
                        input bit noise);
    bit ld, st, bad, e_err, e_req, got, g_err, acc_on, cur_we, saw_req;
    int e_cyc, cyc, wc, d, nb, sh, j0;
    logic [31:0] old, e_new, mask, w_exp;
    logic [31:0] s_word [2];
    logic [15:0] s_half [2];
    logic [7:0]  s_byte [2];
    logic        s_sel [2];
    logic        s_wbx [2];
    ld = (o == 3'd0) || (o == 3'd1) || (o == 3'd2);
    st = (o == 3'd4) || (o == 3'd5) || (o == 3'd6);
    bad = !(ld || st);
`ifdef ALIGN_CHECK_EN
    if (o == 3'd0 && a[1:0] != 2'b00) bad = 1;
    if ((o == 3'd1 || o == 3'd5) && a[0]) bad = 1;
`endif
    old = mem[a[5:2]];
    e_err = 1;
    e_cyc = 1;
    if (!bad) begin
      if (o == 3'd4) begin
        e_err = (dw >= TO);
        e_cyc = e_err ? 1 + TO : 2 + dw;
      end else if (ld) begin
        e_err = (dr >= TO);
        e_cyc = e_err ? 1 + TO : 2 + dr;
      end else if (dr >= TO) begin
        e_cyc = 1 + TO;
      end else if (dw >= TO) begin
        e_cyc = 2 + dr + TO;
      end else begin
        e_err = 0;
        e_cyc = 3 + dr + dw;
      end
    end
    e_req = !bad;
    nb = (o == 3'd6) ? 1 : (o == 3'd5) ? 2 : 4;
    sh = (nb == 1) ? 8 * int'(a[1:0]) : (nb == 2) ? 16 * int'(a[1]) : 0;
    mask = (nb == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * nb)) - 32'd1) << sh);
    e_new = (old & ~mask) | ((wd << sh) & mask);
    w_exp = {a[31:2], 2'b00};

    @(negedge clk);
    start = 1; op = o; addr = a; wdata = wd;
    got = 0; g_err = 0; cyc = 0; acc_on = 0; cur_we = 0; wc = 0; saw_req = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      mem_ready = 0;
      if (mem_req) begin
        saw_req = 1;
        if (!acc_on || mem_we != cur_we) begin
          acc_on = 1; cur_we = mem_we; wc = 0;
        end
        n_cmp++;
        if (mem_addr !== w_exp) begin
          n_bad++;
          $display("FAIL mem_addr op=%0d got=%h exp=%h", o, mem_addr, w_exp);
        end
        d = mem_we ? dw : dr;
        if (mem_we) begin
          n_cmp++;
          if (ld || mem_wdata !== e_new) begin
            n_bad++;
            $display("FAIL mem_wdata op=%0d a=%h got=%h exp=%h", o, a, mem_wdata, e_new);
          end
          if (wc == d) mem[a[5:2]] = e_new;
        end else begin
          mem_rdata = mem[a[5:2]];
        end
        mem_ready = (wc == d);
        wc++;
      end else begin
        acc_on = 0;
      end
      if (done) begin
        got = 1; cyc = k; g_err = err;
        s_word[0] = word_out; s_half[0] = ext_half; s_byte[0] = ext_byte;
        s_sel[0] = ext_sel; s_wbx[0] = wb_ext;
      end
      if (noise) begin
        start = 1'($urandom); op = 3'($urandom);
        addr = $urandom; wdata = $urandom;
      end else begin
        start = 0;
      end
    end

    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL no_done op=%0d a=%h within 60 cycles", o, a);
    end
    n_cmp++;
    if (cyc != e_cyc) begin
      n_bad++;
      $display("FAIL latency op=%0d dr=%0d dw=%0d got=%0d exp=%0d", o, dr, dw, cyc, e_cyc);
    end
    n_cmp++;
    if (g_err != e_err) begin
      n_bad++;
      $display("FAIL err op=%0d a=%h got=%0d exp=%0d", o, a, g_err, e_err);
    end
    n_cmp++;
    if (saw_req != e_req) begin
      n_bad++;
      $display("FAIL mem_req_seen op=%0d a=%h got=%0d exp=%0d", o, a, saw_req, e_req);
    end

    @(negedge clk);
    start = 0; mem_ready = 0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_idle op=%0d got busy=%b done=%b exp 0 0", o, busy, done);
    end
    s_word[1] = word_out; s_half[1] = ext_half; s_byte[1] = ext_byte;
    s_sel[1] = ext_sel; s_wbx[1] = wb_ext;

    if (ld && !e_err) begin
      have_ld = 1; ld_op = o; ld_word = old;
      ld_half = 16'(old >> (16 * int'(a[1])));
      ld_byte = 8'(old >> (8 * int'(a[1:0])));
    end
    j0 = got ? 0 : 1;
    if (have_ld) begin
      for (int j = j0; j < 2; j++) begin
        n_cmp++;
        if (s_wbx[j] !== (ld_op != 3'd0)) begin
          n_bad++;
          $display("FAIL wb_ext snap=%0d got=%b exp=%b", j, s_wbx[j], ld_op != 3'd0);
        end
        n_cmp++;
        if (ld_op == 3'd0 && s_word[j] !== ld_word) begin
          n_bad++;
          $display("FAIL word_out snap=%0d got=%h exp=%h", j, s_word[j], ld_word);
        end else if (ld_op != 3'd0 && s_sel[j] !== (ld_op == 3'd2)) begin
          n_bad++;
          $display("FAIL ext_sel snap=%0d got=%b exp=%b", j, s_sel[j], ld_op == 3'd2);
        end else if (ld_op == 3'd1 && s_half[j] !== ld_half) begin
          n_bad++;
          $display("FAIL ext_half snap=%0d got=%h exp=%h", j, s_half[j], ld_half);
        end else if (ld_op == 3'd2 && s_byte[j] !== ld_byte) begin
          n_bad++;
          $display("FAIL ext_byte snap=%0d got=%h exp=%h", j, s_byte[j], ld_byte);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    #12;
    n_cmp++;
    if ({mem_req, mem_we, busy, done, err, ext_sel, wb_ext} !== 7'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || word_out !== 32'h0 ||
        ext_half !== 16'h0 || ext_byte !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got req=%b busy=%b done=%b word=%h exp all zero",
               mem_req, busy, done, word_out);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ext;
    mem[0] = 32'hAB00_0000;
    run_op(3'd2, 32'h0000_0103, 32'h0, 0, 0, 0);
    mem[0] = 32'hFFFC_1234;
    run_op(3'd1, 32'h0000_0102, 32'h0, 0, 0, 0);
    ext = {{16{ext_half[15]}}, ext_half};
    n_cmp++;
    if (ext !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL lh_signext got=%h exp=fffffffc", ext);
    end
    mem[0] = 32'h1122_3344;
    run_op(3'd6, 32'h0000_0201, 32'h0000_005A, 0, 0, 0);
    run_op(3'd5, 32'h0000_0202, 32'hCAFE_BEEF, 1, 2, 0);
    run_op(3'd4, 32'h0000_0208, 32'h0BAD_F00D, 0, 0, 0);
    run_op(3'd0, 32'h0000_0208, 32'h0, 2, 0, 0);
  endtask

  task automatic test_timeout();
    run_op(3'd0, 32'h0000_0010, 32'h0, 99, 0, 0);
    run_op(3'd0, 32'h0000_0010, 32'h0, 0, 0, 0);
    run_op(3'd0, 32'h0000_0014, 32'h0, TO - 1, 0, 0);
    run_op(3'd2, 32'h0000_0015, 32'h0, TO, 0, 0);
    run_op(3'd6, 32'h0000_0022, 32'h77, 1, 99, 0);
    run_op(3'd5, 32'h0000_0022, 32'h1357, TO - 1, TO - 1, 0);
    run_op(3'd4, 32'h0000_0030, 32'h2468_ACE0, 0, TO, 0);
  endtask

  task automatic test_illegal_and_align();
    run_op(3'd3, 32'h0000_0040, 32'h0, 0, 0, 0);
    run_op(3'd7, 32'h0000_0044, 32'h0, 0, 0, 0);
    mem[0] = 32'h5555_AAAA;
    run_op(3'd1, 32'h0000_0101, 32'h0, 0, 0, 0);
    run_op(3'd0, 32'h0000_0102, 32'h0, 0, 0, 0);
    run_op(3'd5, 32'h0000_0103, 32'hFFFF_1234, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] ops [10];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd2, 3'd6, 3'd3, 3'd7};
    for (int i = 0; i < 60; i++) begin
      run_op(ops[$urandom_range(0, 9)], $urandom, $urandom,
             pick_dly(), pick_dly(), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    start = 1; op = 3'd4; addr = 32'h0000_0300; wdata = 32'h1234_5678;
    @(negedge clk);
    start = 0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_entered got req=%b we=%b exp 1 1", mem_req, mem_we);
    end
    #2;
    reset_n = 0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_abort got req=%b busy=%b done=%b exp 0 0 0",
               mem_req, busy, done);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done cyc=%0d got done=%b req=%b exp 0 0", k, done, mem_req);
      end
    end
    reset_n = 1;
    have_ld = 0;
    @(negedge clk);
    run_op(3'd0, 32'h0000_0300, 32'h0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    test_reset();
    test_directed();
    test_timeout();
    test_illegal_and_align();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
